// File: rtl/uart_receiver_if.sv
// Purpose: groups the UART receive line with the decoded byte, strobe and status flags.
// Latency: none, wiring only.
// Backpressure: none; rx_done is a one-cycle strobe and the consumer must take it when it fires.
interface uart_receiver_if;
  logic       serial_input_rx;
  logic [7:0] data;
  logic       rx_done;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  // Side that drives the serial line and consumes the decoded results.
  modport master (
    output serial_input_rx,
    input  data,
    input  rx_done,
    input  parity_error,
    input  framing_error,
    input  busy
  );

  // The receiver itself.
  modport slave (
    input  serial_input_rx,
    output data,
    output rx_done,
    output parity_error,
    output framing_error,
    output busy
  );
endinterface

// File: rtl/uart_receiver.sv
// Purpose: 8E1 UART receiver. Bits are sampled mid-bit and the byte is reported with per-frame parity/framing flags.
// Latency: rx_done fires about 10.5 bit periods after the start edge is seen on the synchronised line.
// Backpressure: none; data and flags hold until the next frame completes.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 5208  // must be >= 4 and even
) (
  input logic         clk,
  input logic         reset,
  uart_receiver_if.slave link
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] HALF_TERM = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_TERM = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic          rx_prev;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [7:0]    data_q;
  logic          rx_done_q;
  logic          parity_error_q;
  logic          framing_error_q;
  logic          busy_q;

  logic          fall;
  logic          bit_tick;
  logic [TW-1:0] term;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection; all idle high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= link.serial_input_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // A frame may only start on a real 1->0 transition; a line that is already low is ignored.
  assign fall = rx_prev & ~rx_s;

  // START waits half a bit so that every later sample lands mid-bit.
  assign term     = (state == S_START) ? HALF_TERM : FULL_TERM;
  assign bit_tick = (timer == term);

  // Receive FSM: owns the bit timer, bit counter, shift register and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      timer           <= '0;
      bit_cnt         <= '0;
      shift           <= '0;
      par_bit         <= 1'b0;
      data_q          <= 8'h00;
      rx_done_q       <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (fall) begin
            state  <= S_START;
            busy_q <= 1'b1;
          end
        end

        S_START: begin
          if (bit_tick) begin
            timer <= '0;
            if (!rx_s) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_DATA: begin
          if (bit_tick) begin
            timer <= '0;
            // LSB arrives first, so shifting right leaves it in bit 0 after eight samples.
            shift <= {rx_s, shift[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= S_PARITY;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_PARITY: begin
          if (bit_tick) begin
            timer   <= '0;
            par_bit <= rx_s;
            state   <= S_STOP;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_STOP: begin
          if (bit_tick) begin
            // Report every completed frame, even a bad one; data is updated regardless.
            timer           <= '0;
            data_q          <= shift;
            parity_error_q  <= par_bit ^ (^shift);
            framing_error_q <= ~rx_s;
            rx_done_q       <= 1'b1;
            busy_q          <= 1'b0;
            // Leaving at mid stop bit lets a back-to-back start edge be caught.
            state           <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: begin
          state  <= S_IDLE;
          timer  <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign link.data          = data_q;
  assign link.rx_done       = rx_done_q;
  assign link.parity_error  = parity_error_q;
  assign link.framing_error = framing_error_q;
  assign link.busy          = busy_q;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Receive half of the UART link; it deserialises frames produced by the team's UART transmitter. Frame format is 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, and 1 stop bit (1); the line idles high. The block oversamples the line with an internal bit timer and samples each bit at mid-bit. It delivers the byte with a one-cycle done strobe plus sticky-free per-frame error flags, for consumption by downstream logic such as display or loop-back modules.

## Interface
- CLKS_PER_BIT, 5208: clock cycles per bit period (50 MHz / 9600 baud); must be ≥ 4 and even.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- serial_input_rx  input  1  asynchronous serial line, idle high.
- data  output  8  last received byte; holds its value until the next frame completes.
- rx_done  output  1  one-cycle strobe; frame complete and data/flags valid.
- parity_error  output  1  received parity ≠ XOR(data); valid with and held after rx_done.
- framing_error  output  1  stop bit sampled 0; valid with and held after rx_done.
- busy  output  1  high from start-bit detection until return to IDLE.

## Operation
- Synchroniser: 2-flop synchroniser on serial_input_rx (reset value 1); all logic uses the synchronised bit rx_s. An edge detector flags the 1→0 transition of rx_s.
- Bit timer: counter 0..CLKS_PER_BIT-1, cleared on every state entry. bit_tick fires when it reaches its terminal value: CLKS_PER_BIT/2-1 in START, CLKS_PER_BIT-1 elsewhere.
- Bit counter: 0..7, indexes the data bits; cleared on entry to DATA.
- Shift register: 8 bits, shifts right with rx_s entering bit 7, so the first bit received ends in data[0].
- FSM states:
  - IDLE: busy=0. A falling edge of rx_s → START.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. rx_s=0 → DATA. rx_s=1 → IDLE (glitch rejected; no rx_done, flags unchanged).
  - DATA: on each bit_tick, shift in rx_s and increment the bit counter. After the 8th sample → PARITY.
  - PARITY: on bit_tick, capture the parity bit → STOP.
  - STOP: on bit_tick, sample the stop bit. Then, in the same edge:
    - load data with the shift register;
    - set parity_error = p ^ (^shift);
    - set framing_error = ~rx_s;
    - assert rx_done for the next cycle;
    - go to IDLE.
- The block returns to IDLE at mid-stop-bit, so a start bit immediately following the stop bit is detected.
- data is updated even when an error flag is set.
- A frame with framing_error=1 is still reported.
- If the line is low on return to IDLE, no new frame starts until rx_s has been seen high and then falls (edge-triggered only).

## Timing
- Reset values:
  - data=8'h00, rx_done=0, parity_error=0, framing_error=0, busy=0;
  - FSM=IDLE, synchroniser flops=1, counters=0.
- Reset asserted mid-frame aborts immediately. No rx_done is produced for the aborted frame.
- Let t0 be the first clock at which rx_s=0 after a falling edge; t0 is 2 cycles after the line falls.
  - busy rises at t0+1.
  - The start sample occurs at t0+CLKS_PER_BIT/2.
  - Data bit k is sampled at t0+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT.
  - Parity is sampled at t0+9.5·CLKS_PER_BIT.
  - Stop is sampled at t0+10.5·CLKS_PER_BIT.
  - rx_done, data and flags are valid in the following cycle; busy falls in that same cycle.
- Permitted tolerance: ±1 cycle on every sample point. The bench checks rx_done within that window.
- rx_done is never high for 2 consecutive cycles.

## Test plan
- CLKS_PER_BIT=16. Send 0xA5 (bits 1,0,1,0,0,1,0,1, parity 0, stop 1) → one rx_done pulse; data=0xA5, parity_error=0, framing_error=0; busy low afterwards.
- Send 0x01 with parity bit forced to 0 → rx_done; data=0x01, parity_error=1, framing_error=0.
- Send 0x3C with stop bit driven 0 → rx_done; data=0x3C, framing_error=1. Then hold the line high and send 0x55 → data=0x55, framing_error=0.
- Pull the line low for 4 cycles, then high → busy pulses, no rx_done, data unchanged, FSM back in IDLE by 8+2 cycles after the fall.
- Back-to-back 0x00 then 0xFF with zero idle gap → two rx_done pulses 11·16 cycles apart (±1); data 0x00 then 0xFF; no errors.
- Assert reset during data bit 4 of 0x81, release, then send 0x7E → no rx_done for the aborted frame; outputs at reset values during reset; next rx_done has data=0x7E.
